// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pipe_reg.sv
// IF/ID pipeline register: captures a fetched {pc, inst} pair and holds it
// until decode takes it; a flush drops it, reset reloads the NOP.
module fetch_pipe_reg
  import fetch_pkg::*;
#(
  parameter int AW = 64,
  parameter int IW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic [AW-1:0] pc_i,
  input  logic [IW-1:0] inst_i,
  output logic          valid_o,
  output logic [AW-1:0] pc_o,
  output logic [IW-1:0] inst_o
);

  logic          valid_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] inst_q;

  // Flush only clears valid; the stale payload is harmless once invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= IW'(NOP_INST);
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory, feeds
// decode through the IF/ID register, handles redirects and misaligned faults.
module fetch_unit #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    INST_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  output logic [ADDR_WIDTH-1:0]  imem_addr_out,
  input  logic [INST_WIDTH-1:0]  imem_data_in,
  input  logic                   redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_in,
  output logic                   id_valid_out,
  output logic [ADDR_WIDTH-1:0]  id_pc_out,
  output logic [INST_WIDTH-1:0]  id_inst_out,
  input  logic                   id_ready_in,
  output logic                   fault_out,
  output logic [ADDR_WIDTH-1:0]  fault_pc_out,
  output logic [63:0]            fetch_count_out,
  output fetch_pkg::fetch_state_t state_out
);

  import fetch_pkg::*;

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] fault_pc_q;
  logic [63:0]           count_q;

  logic redir_take;
  logic redir_aligned;
  logic adv;
  logic load;
  logic accept;

  // Handshake: decode owns the instruction on id_* in any cycle where
  // id_valid_out && id_ready_in; until then id_* is held stable. A redirect
  // in the same cycle overrides the transfer (wrong path, not counted).
  assign redir_take    = redirect_valid_in && (state_q != BOOT);
  assign redir_aligned = (redirect_pc_in[1:0] == 2'b00);
  assign adv           = !id_valid_out || id_ready_in;
  assign load          = (state_q == RUN) && !redirect_valid_in && adv;
  assign accept        = id_valid_out && id_ready_in && !redirect_valid_in;
  assign pc_d          = pc_q + ADDR_WIDTH'(PC_STEP);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      if (accept) begin
        count_q <= count_q + 64'd1;
      end
      case (state_q)
        BOOT: state_q <= RUN;
        RUN, FAULT: begin
          if (redirect_valid_in) begin
            if (redir_aligned) begin
              state_q <= RUN;
              pc_q    <= redirect_pc_in;
              fault_q <= 1'b0;
            end else begin
              state_q    <= FAULT;
              fault_q    <= 1'b1;
              fault_pc_q <= redirect_pc_in;
            end
          end else if ((state_q == RUN) && adv) begin
            pc_q <= pc_d;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  fetch_pipe_reg #(
    .AW (ADDR_WIDTH),
    .IW (INST_WIDTH)
  ) u_pipe (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .load_i  (load),
    .flush_i (redir_take),
    .pc_i    (pc_q),
    .inst_i  (imem_data_in),
    .valid_o (id_valid_out),
    .pc_o    (id_pc_out),
    .inst_o  (id_inst_out)
  );

  assign imem_addr_out   = pc_q;
  assign fault_out       = fault_q;
  assign fault_pc_out    = fault_pc_q;
  assign fetch_count_out = count_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequence with a scoreboard of accepted
// instructions plus a second instance checking PC wrap from the top vector.
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  logic [63:0] addr1, rpc, idpc1, fpc1, cnt1;
  logic [31:0] data1, idinst1;
  logic        rv, rdy, idv1, fault1;
  fetch_pkg::fetch_state_t st1;

  logic [63:0] addr2, rpc2, idpc2, fpc2, cnt2;
  logic [31:0] data2, idinst2;
  logic        rv2, rdy2, idv2, fault2;
  fetch_pkg::fetch_state_t st2;

  logic [95:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit u_dut (
    .clk_in (clk), .rst_n_in (rst_n),
    .imem_addr_out (addr1), .imem_data_in (data1),
    .redirect_valid_in (rv), .redirect_pc_in (rpc),
    .id_valid_out (idv1), .id_pc_out (idpc1), .id_inst_out (idinst1),
    .id_ready_in (rdy), .fault_out (fault1), .fault_pc_out (fpc1),
    .fetch_count_out (cnt1), .state_out (st1)
  );

  fetch_unit #(.RESET_VECTOR (64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk_in (clk), .rst_n_in (rst_n),
    .imem_addr_out (addr2), .imem_data_in (data2),
    .redirect_valid_in (rv2), .redirect_pc_in (rpc2),
    .id_valid_out (idv2), .id_pc_out (idpc2), .id_inst_out (idinst2),
    .id_ready_in (rdy2), .fault_out (fault2), .fault_pc_out (fpc2),
    .fetch_count_out (cnt2), .state_out (st2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h11;
      64'h4:   return 32'h22;
      64'h8:   return 32'h33;
      64'hC:   return 32'h44;
      default: return 32'hCAFE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  always_comb data1 = mem_word(addr1);
  always_comb data2 = mem_word(addr2);

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " id_valid"}, 64'(idv1), 64'd0);
    chk({tag, " id_pc"}, idpc1, 64'd0);
    chk({tag, " id_inst"}, 64'(idinst1), 64'h13);
    chk({tag, " fault"}, 64'(fault1), 64'd0);
    chk({tag, " fault_pc"}, fpc1, 64'd0);
    chk({tag, " count"}, cnt1, 64'd0);
    chk({tag, " imem_addr"}, addr1, 64'd0);
    chk({tag, " state"}, 64'(st1), 64'(fetch_pkg::BOOT));
  endtask

  // Scoreboard monitor: every accepted, non-redirected instruction is popped
  always @(negedge clk) begin
    if (rst_n && idv1 && rdy && !rv) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=0x%0h inst=0x%0h expected none", idpc1, idinst1);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if ({idpc1, idinst1} !== e) begin
          n_fail++;
          $display("FAIL sb_accept: got pc=0x%0h inst=0x%0h expected pc=0x%0h inst=0x%0h",
                   idpc1, idinst1, e[95:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rv = 1'b0; rpc = '0;
    rv2 = 1'b0; rpc2 = '0; rdy2 = 1'b1;
    step();
    chk_reset_state("reset");
    chk("wrap reset addr", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back({64'h0, 32'h11});
    exp_q.push_back({64'h4, 32'h22});
    exp_q.push_back({64'h8, 32'h33});
    rst_n = 1'b1;

    step();  // BOOT -> RUN, nothing captured yet
    chk("e1 state", 64'(st1), 64'(fetch_pkg::RUN));
    chk("e1 id_valid", 64'(idv1), 64'd0);
    step();
    chk("e2 id_valid", 64'(idv1), 64'd1);
    chk("e2 id_pc", idpc1, 64'h0);
    chk("e2 id_inst", 64'(idinst1), 64'h11);
    chk("e2 imem_addr", addr1, 64'h4);
    chk("wrap first pc", idpc2, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap first inst", 64'(idinst2), 64'hCAFE_FFFC);
    step();
    chk("e3 id_pc", idpc1, 64'h4);
    chk("e3 count", cnt1, 64'd1);
    chk("wrap second pc", idpc2, 64'h0);
    chk("wrap second inst", 64'(idinst2), 64'h11);
    rdy = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall id_valid", 64'(idv1), 64'd1);
      chk("stall id_pc", idpc1, 64'h4);
      chk("stall id_inst", 64'(idinst1), 64'h22);
      chk("stall imem_addr", addr1, 64'h8);
      chk("stall count", cnt1, 64'd1);
    end
    rdy = 1'b1;

    step();
    chk("e7 id_pc", idpc1, 64'h8);
    chk("e7 count", cnt1, 64'd2);
    step();
    chk("e8 id_pc", idpc1, 64'hC);
    chk("e8 count", cnt1, 64'd3);
    rv = 1'b1; rpc = 64'h100;
    exp_q.push_back({64'h100, 32'hCAFE_0100});

    step();  // flush: held 0xC dropped
    chk("redir id_valid", 64'(idv1), 64'd0);
    chk("redir count", cnt1, 64'd3);
    chk("redir imem_addr", addr1, 64'h100);
    rv = 1'b0;
    step();
    chk("post redir id_valid", 64'(idv1), 64'd1);
    chk("post redir id_pc", idpc1, 64'h100);
    step();
    chk("e11 count", cnt1, 64'd4);
    rv = 1'b1; rpc = 64'h102;

    step();
    chk("fault flag", 64'(fault1), 64'd1);
    chk("fault pc", fpc1, 64'h102);
    chk("fault id_valid", 64'(idv1), 64'd0);
    chk("fault count", cnt1, 64'd4);
    chk("fault pc hold", addr1, 64'h108);
    chk("fault state", 64'(st1), 64'(fetch_pkg::FAULT));
    rv = 1'b0;
    step();
    chk("fault stay", 64'(fault1), 64'd1);
    chk("fault stay id_valid", 64'(idv1), 64'd0);
    rv = 1'b1; rpc = 64'h200;
    exp_q.push_back({64'h200, 32'hCAFE_0200});
    step();
    chk("fault exit flag", 64'(fault1), 64'd0);
    chk("fault exit fault_pc", fpc1, 64'h102);
    chk("fault exit addr", addr1, 64'h200);
    chk("fault exit state", 64'(st1), 64'(fetch_pkg::RUN));
    rv = 1'b0;
    step();
    chk("e15 id_pc", idpc1, 64'h200);
    step();
    chk("e16 count", cnt1, 64'd5);
    rdy = 1'b0;
    step();
    chk("e17 id_pc", idpc1, 64'h204);
    chk("e17 id_inst", 64'(idinst1), 64'hCAFE_0204);
    rst_n = 1'b0;

    step();  // reset during stall with valid data
    chk_reset_state("stall reset");
    rst_n = 1'b1; rv = 1'b1; rpc = 64'h300; rdy = 1'b1;
    exp_q.push_back({64'h0, 32'h11});
    step();  // redirect in BOOT ignored
    chk("boot redir addr", addr1, 64'h0);
    chk("boot redir state", 64'(st1), 64'(fetch_pkg::RUN));
    rv = 1'b0;
    step();
    chk("reboot id_pc", idpc1, 64'h0);
    chk("reboot id_valid", 64'(idv1), 64'd1);
    step();
    chk("reboot count", cnt1, 64'd1);
    rdy = 1'b0;
    step();
    step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory address. It captures the 32-bit instruction returned combinationally into an IF/ID pipeline register, which decode consumes through a valid/ready handshake. It also handles redirects (branch/jump/trap), decode back-pressure, misaligned-target faults and a retired-fetch counter.

Parameters:
RESET_VECTOR, 64'h0, PC value loaded on reset; must be 4-byte aligned.
ADDR_WIDTH, 64, PC / instruction address width.
INST_WIDTH, 32, instruction width.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_n_in  input  1  reset; one clock, synchronous, active-low.
imem_addr_out  output  64  address to instruction memory; equals pc_q (combinational from register).
imem_data_in  input  32  instruction word returned combinationally by instruction memory for imem_addr_out.
redirect_valid_in  input  1  redirect request from execute/trap logic.
redirect_pc_in  input  64  redirect target.
id_valid_out  output  1  IF/ID register holds a valid instruction.
id_pc_out  output  64  PC of held instruction.
id_inst_out  output  32  held instruction.
id_ready_in  input  1  decode accepts held instruction this cycle.
fault_out  output  1  high while in FAULT state.
fault_pc_out  output  64  misaligned target that caused the fault.
fetch_count_out  output  64  count of instructions accepted by decode.

Behaviour:
- States: BOOT, RUN, FAULT. Reset (rst_n_in low at an edge) forces BOOT regardless of current state or handshake in flight.
- Reset values: pc_q=RESET_VECTOR, id_valid_out=0, id_pc_out=0, id_inst_out=32'h00000013 (NOP), fault_out=0, fault_pc_out=0, fetch_count_out=0.
- BOOT: no capture. Unconditionally goes to RUN next edge; a redirect in BOOT is ignored.
- Advance condition in RUN: adv = !id_valid_out || id_ready_in.
- RUN, no redirect, adv: capture {pc_q, imem_data_in} into IF/ID, set id_valid_out=1, pc_q <= pc_q + 4. The add wraps modulo 2^64.
- RUN, no redirect, !adv (stall): pc_q and IF/ID hold. id_valid/pc/inst must stay stable until accepted.
- Latency: an instruction at PC X appears on id_* one edge after pc_q==X. The first valid instruction after reset release is at edge 2 (edge 1 is BOOT->RUN).
- Redirect (any state except BOOT) has priority over stall and advance:
  - Aligned target (redirect_pc_in[1:0]==0): pc_q <= target, id_valid_out <= 0 (flush, one-bubble penalty), state <= RUN.
  - Misaligned target: state <= FAULT, fault_pc_out <= target, id_valid_out <= 0, pc_q holds.
- FAULT: fault_out=1. No fetch, id_valid_out=0. Exit only by an aligned redirect, which goes to RUN and clears fault_out. fault_pc_out holds until the next fault or reset.
- fetch_count_out increments by 1 on id_valid_out && id_ready_in && !redirect_valid_in. A handshake in a redirect cycle is wrong-path and is not counted. The counter wraps modulo 2^64.
- Simultaneous redirect + id_ready_in: flush wins; the held instruction is dropped, not counted.
- imem_addr_out is never gated; the memory read is side-effect-free.

Decomposition:
- Package fetch_pkg: ADDR_WIDTH/INST_WIDTH constants, NOP_INST=32'h00000013, PC_STEP=4, enum fetch_state_t {BOOT, RUN, FAULT}.
- Sub-module fetch_pipe_reg: the IF/ID register with valid/ready, flush and reset-to-NOP. fetch_unit instantiates one.

Test Plan:
- Reset, then RUN with id_ready_in=1, memory words 0x11,0x22,0x33 at 0,4,8 -> id_valid_out rises at edge 2 with pc=0/inst=0x11, then pc=4/0x22, pc=8/0x33 on consecutive edges; fetch_count_out=3.
- Hold id_ready_in=0 for 3 cycles with id_pc_out=4 -> id_pc/inst stable at 4/0x22, imem_addr_out stuck at 8, count unchanged. Release -> resumes 8, 12.
- Redirect to 0x100 while id_valid_out=1 and id_ready_in=1 -> next cycle id_valid_out=0 and count not incremented. The following cycle delivers pc=0x100.
- Redirect to 0x102 -> fault_out=1, fault_pc_out=0x102, id_valid_out stays 0. A later redirect to 0x200 -> fault_out=0 and pc=0x200 delivered.
- RESET_VECTOR=64'hFFFF_FFFF_FFFF_FFFC -> first pc=...FFFC, second pc=0 (wrap).
- rst_n_in low during stall with valid data -> next edge all outputs at reset values, pc_q=RESET_VECTOR, BOOT re-entered.
